ps2_scancode_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_key_map.sv | 27 ++
 rtl/ps2_scancode_decoder.sv | 181 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_e;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_FA    = 8'hFA;
    localparam logic [7:0] SC_AA    = 8'hAA;
    localparam logic [7:0] SC_EE    = 8'hEE;
    localparam logic [7:0] SC_FE    = 8'hFE;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] KEY_ESC   = 3'd0;
    localparam logic [2:0] KEY_S     = 3'd1;
    localparam logic [2:0] KEY_P     = 3'd2;
    localparam logic [2:0] KEY_R     = 3'd3;
    localparam logic [2:0] KEY_UP    = 3'd4;
    localparam logic [2:0] KEY_DOWN  = 3'd5;
    localparam logic [2:0] KEY_LEFT  = 3'd6;
    localparam logic [2:0] KEY_RIGHT = 3'd7;

endpackage

// File: rtl/ps2_key_map.sv
// Maps a scan code to its game-key slot in KEYS_HELD; ext is ignored so
// keypad keys alias the arrow keys.
module ps2_key_map
    import ps2_pkg::*;
(
    input  logic [7:0] code_i,
    output logic       hit_o,
    output logic [2:0] idx_o
);

    always_comb begin
        hit_o = 1'b1;
        idx_o = KEY_ESC;
        case (code_i)
            SC_ESC:   idx_o = KEY_ESC;
            SC_S:     idx_o = KEY_S;
            SC_P:     idx_o = KEY_P;
            SC_R:     idx_o = KEY_R;
            SC_UP:    idx_o = KEY_UP;
            SC_DOWN:  idx_o = KEY_DOWN;
            SC_LEFT:  idx_o = KEY_LEFT;
            SC_RIGHT: idx_o = KEY_RIGHT;
            default:  hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 prefix parser: one registered key event per make/break sequence plus
// held flags for the game keys. PS2_TYPEMATIC_FILTER_EN drops repeated makes.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       KEY_EVENT,
    output logic [7:0] KEYS_HELD,
    output logic       RX_ERROR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(PAUSE_SKIP + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [SW-1:0]  skip_q, skip_d;
    logic           timeout;

    logic           ev, ev_ext, ev_brk, err_d, emit;
    logic           hit;
    logic [2:0]     idx;
    logic [7:0]     held_q, held_d;
    logic [7:0]     code_q;
    logic           ext_q, brk_q, event_q, err_q;

    ps2_key_map u_key_map (
        .code_i (RX_DATA),
        .hit_o  (hit),
        .idx_o  (idx)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            skip_q  <= skip_d;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        skip_d  = skip_q;
        timeout = 1'b0;
        if (state_q != ST_IDLE && !RX_VALID) begin
            if (timer_q == TMAX) begin
                state_d = ST_IDLE;
                skip_d  = '0;
                timeout = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        if (RX_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (RX_DATA == SC_E0) state_d = ST_EXT;
                    else if (RX_DATA == SC_F0) state_d = ST_BRK;
                    else if (RX_DATA == SC_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = SW'(PAUSE_SKIP);
                    end
                end
                ST_EXT:     state_d = (RX_DATA == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK,
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    if (skip_q <= SW'(1)) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 1'b1;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ev     = 1'b0;
        ev_ext = 1'b0;
        ev_brk = 1'b0;
        err_d  = timeout;
        if (RX_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    case (RX_DATA)
                        SC_E0, SC_F0, SC_E1, SC_FA, SC_AA, SC_EE, SC_FE: ;
                        SC_ERR0, SC_ERRF: err_d = 1'b1;
                        default: ev = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    ev     = (RX_DATA != SC_F0);
                    ev_ext = 1'b1;
                end
                ST_BRK: begin
                    ev     = 1'b1;
                    ev_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev     = 1'b1;
                    ev_ext = 1'b1;
                    ev_brk = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        held_d = held_q;
        if (ev && hit) held_d[idx] = !ev_brk;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Zero is a safe "empty" marker: 00 is an error byte, never a make.
    logic [8:0] last_q, last_d;
    logic       rep;

    always_comb begin
        rep    = ev && !ev_brk && (last_q == {ev_ext, RX_DATA});
        last_d = last_q;
        if (ev && !ev_brk) last_d = {ev_ext, RX_DATA};
        else if (ev && ev_brk && last_q == {ev_ext, RX_DATA}) last_d = '0;
        emit = ev && !rep;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) last_q <= '0;
        else          last_q <= last_d;
    end
`else
    assign emit = ev;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            code_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            event_q <= 1'b0;
            err_q   <= 1'b0;
            held_q  <= '0;
        end else begin
            event_q <= emit;
            err_q   <= err_d;
            held_q  <= held_d;
            if (emit) begin
                code_q <= RX_DATA;
                ext_q  <= ev_ext;
                brk_q  <= ev_brk;
            end
        end
    end

    assign KEY_CODE  = code_q;
    assign KEY_EXT   = ext_q;
    assign KEY_BREAK = brk_q;
    assign KEY_EVENT = event_q;
    assign KEYS_HELD = held_q;
    assign RX_ERROR  = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a 16-cycle prefix timeout.
module tb_ps2_scancode_decoder;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_VALID = 1'b0;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_BREAK;
    logic       KEY_EVENT;
    logic [7:0] KEYS_HELD;
    logic       RX_ERROR;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;
    int ev_base;
    int err_cnt;
    int err_at;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(16), .PAUSE_SKIP(7)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .KEY_CODE  (KEY_CODE),
        .KEY_EXT   (KEY_EXT),
        .KEY_BREAK (KEY_BREAK),
        .KEY_EVENT (KEY_EVENT),
        .KEYS_HELD (KEYS_HELD),
        .RX_ERROR  (RX_ERROR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (KEY_EVENT) ev_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives one byte for one cycle. Back-to-back
    // calls keep RX_VALID high on consecutive cycles.
    task automatic send(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        idle(3);
        check("rst_code",  {24'd0, KEY_CODE}, 32'h00);
        check("rst_event", {31'd0, KEY_EVENT}, 32'h0);
        check("rst_held",  {24'd0, KEYS_HELD}, 32'h00);
        check("rst_err",   {31'd0, RX_ERROR}, 32'h0);
        RESET_N = 1'b1;
        idle(2);

        // plain make of S
        send(8'h1B);
        check("s_event", {31'd0, KEY_EVENT}, 32'h1);
        check("s_code",  {24'd0, KEY_CODE}, 32'h1B);
        check("s_ext",   {31'd0, KEY_EXT}, 32'h0);
        check("s_brk",   {31'd0, KEY_BREAK}, 32'h0);
        check("s_held",  {24'd0, KEYS_HELD}, 32'h02);
        idle(1);
        check("s_pulse", {31'd0, KEY_EVENT}, 32'h0);

        // extended make/break of UP, bytes back-to-back
        ev_base = ev_cnt;
        send(8'hE0); send(8'h75);
        check("up_mk_ev",   {31'd0, KEY_EVENT}, 32'h1);
        check("up_mk_ext",  {31'd0, KEY_EXT}, 32'h1);
        check("up_mk_brk",  {31'd0, KEY_BREAK}, 32'h0);
        check("up_mk_held", {24'd0, KEYS_HELD}, 32'h12);
        idle(2);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_bk_ext",  {31'd0, KEY_EXT}, 32'h1);
        check("up_bk_brk",  {31'd0, KEY_BREAK}, 32'h1);
        check("up_bk_held", {24'd0, KEYS_HELD}, 32'h02);
        idle(2);
        check("up_evcnt", ev_cnt - ev_base, 32'd2);

        // Pause sequence produces nothing, then ESC make
        ev_base = ev_cnt;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(2);
        check("pause_evcnt", ev_cnt - ev_base, 32'd0);
        send(8'h76);
        check("esc_event", {31'd0, KEY_EVENT}, 32'h1);
        check("esc_code",  {24'd0, KEY_CODE}, 32'h76);
        check("esc_brk",   {31'd0, KEY_BREAK}, 32'h0);
        check("esc_held",  {24'd0, KEYS_HELD}, 32'h03);
        idle(2);

        // F0 then silence: one error pulse, 16 cycles on
        send(8'hF0);
        err_cnt = 0;
        err_at  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (RX_ERROR) begin
                err_cnt++;
                err_at = i;
            end
        end
        check("to_errcnt", err_cnt, 32'd1);
        check("to_errat",  err_at, 32'd16);
        send(8'h6B);
        check("to_left_ev",   {31'd0, KEY_EVENT}, 32'h1);
        check("to_left_brk",  {31'd0, KEY_BREAK}, 32'h0);
        check("to_left_held", {24'd0, KEYS_HELD}, 32'h43);
        idle(2);

        // reset in the middle of an E0 prefix
        send(8'hE0);
        RESET_N = 1'b0;
        idle(2);
        check("mrst_held", {24'd0, KEYS_HELD}, 32'h00);
        check("mrst_code", {24'd0, KEY_CODE}, 32'h00);
        check("mrst_ev",   {31'd0, KEY_EVENT}, 32'h0);
        check("mrst_ext",  {31'd0, KEY_EXT}, 32'h0);
        RESET_N = 1'b1;
        idle(2);
        send(8'h6B);
        check("mrst_left_ev",   {31'd0, KEY_EVENT}, 32'h1);
        check("mrst_left_ext",  {31'd0, KEY_EXT}, 32'h0);
        check("mrst_left_held", {24'd0, KEYS_HELD}, 32'h40);
        idle(2);

        // error byte, ignored ack byte, unmapped make
        send(8'h00);
        check("err00_err", {31'd0, RX_ERROR}, 32'h1);
        check("err00_ev",  {31'd0, KEY_EVENT}, 32'h0);
        idle(1);
        send(8'hFA);
        check("fa_ev",  {31'd0, KEY_EVENT}, 32'h0);
        check("fa_err", {31'd0, RX_ERROR}, 32'h0);
        idle(1);
        send(8'h14);
        check("unmap_ev",   {31'd0, KEY_EVENT}, 32'h1);
        check("unmap_held", {24'd0, KEYS_HELD}, 32'h40);
        idle(2);

        // typematic repeats of RIGHT
        ev_base = ev_cnt;
        send(8'h74);
        check("rt_held_set", {24'd0, KEYS_HELD}, 32'hC0);
        idle(1);
        send(8'h74); idle(1);
        send(8'h74); idle(1);
        send(8'hF0); send(8'h74);
        check("rt_held_clr", {24'd0, KEYS_HELD}, 32'h40);
        idle(2);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("rt_evcnt", ev_cnt - ev_base, 32'd2);
`else
        check("rt_evcnt", ev_cnt - ev_base, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
